riscv_data_mem: RTL and testbench

Word-organised data RAM with a request/ready handshake, sitting directly downstream of the data memory interface stage. It accepts byte, halfword and word accesses, steers write data onto the byte lanes selected by the address, and returns the addressed bytes right-aligned and zero-filled after a configurable number of wait states. The upstream stage performs any sign extension.

---
 rtl/riscv_pkg.sv | 66 ++++++
 rtl/riscv_data_mem_if.sv | 35 +++
 rtl/riscv_dmem_array.sv | 36 +++
 rtl/riscv_data_mem.sv | 162 ++++++++++++++++
 tb/tb_riscv_data_mem.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg
//   Shared definitions for the data memory path.
//   - mem_access_size_t : access size encoding carried on data_mem_byte_en_i
//   - dmem_state_t      : riscv_data_mem control FSM states
//   - dmem_strobe       : byte-lane write strobe for a size/offset pair
//   - dmem_wr_lanes     : replicates right-aligned store data onto all lanes
//   - dmem_lane_sel     : extracts the addressed bytes, right-aligned, zero-filled
package riscv_pkg;

    typedef enum logic [1:0] {
        Byte_Access     = 2'b00,
        Halfword_Access = 2'b01,
        Reserved_Access = 2'b10,
        Word_Access     = 2'b11
    } mem_access_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        ACK  = 2'b10
    } dmem_state_t;

    // Misaligned low offset bits are dropped for halfword and word sizes, so
    // callers that want alias behaviour can pass the raw offset.
    function automatic logic [3:0] dmem_strobe(input logic [1:0] size,
                                               input logic [1:0] offset);
        logic [3:0] strobe;
        case (size)
            Byte_Access:     strobe = 4'b0001 << offset;
            Halfword_Access: strobe = 4'b0011 << {offset[1], 1'b0};
            default:         strobe = 4'b1111;
        endcase
        return strobe;
    endfunction

    function automatic logic [31:0] dmem_wr_lanes(input logic [31:0] wr_data,
                                                  input logic [1:0]  size);
        logic [31:0] lanes;
        case (size)
            Byte_Access:     lanes = {4{wr_data[7:0]}};
            Halfword_Access: lanes = {2{wr_data[15:0]}};
            default:         lanes = wr_data;
        endcase
        return lanes;
    endfunction

    function automatic logic [31:0] dmem_lane_sel(input logic [31:0] word,
                                                  input logic [1:0]  size,
                                                  input logic [1:0]  offset);
        logic [31:0] data;
        case (size)
            Byte_Access: begin
                case (offset)
                    2'd0:    data = {24'b0, word[7:0]};
                    2'd1:    data = {24'b0, word[15:8]};
                    2'd2:    data = {24'b0, word[23:16]};
                    default: data = {24'b0, word[31:24]};
                endcase
            end
            Halfword_Access: data = offset[1] ? {16'b0, word[31:16]} : {16'b0, word[15:0]};
            default:         data = word;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/riscv_data_mem_if.sv
// riscv_data_mem_if
//   Request/ready bus between the data memory interface stage (master) and
//   the data RAM (slave).
//
//   Handshake: the master raises data_mem_req_i with addr/size/wr/wr_data
//   stable and holds all of them until it sees mem_ready_o high. mem_ready_o
//   is a single-cycle pulse; mem_rd_data_o and mem_err_o are meaningful only
//   in that cycle. A request still high in the cycle after the pulse is a
//   new access.
//
//   Signals: data_mem_req_i, data_mem_addr_i[31:0], data_mem_byte_en_i[1:0],
//            data_mem_wr_i, data_mem_wr_data_i[31:0]       (master -> slave)
//            mem_rd_data_o[31:0], mem_ready_o, mem_err_o   (slave -> master)
interface riscv_data_mem_if;
    logic        data_mem_req_i;
    logic [31:0] data_mem_addr_i;
    logic [1:0]  data_mem_byte_en_i;
    logic        data_mem_wr_i;
    logic [31:0] data_mem_wr_data_i;
    logic [31:0] mem_rd_data_o;
    logic        mem_ready_o;
    logic        mem_err_o;

    modport master (
        output data_mem_req_i, data_mem_addr_i, data_mem_byte_en_i,
               data_mem_wr_i, data_mem_wr_data_i,
        input  mem_rd_data_o, mem_ready_o, mem_err_o
    );

    modport slave (
        input  data_mem_req_i, data_mem_addr_i, data_mem_byte_en_i,
               data_mem_wr_i, data_mem_wr_data_i,
        output mem_rd_data_o, mem_ready_o, mem_err_o
    );
endinterface

// File: rtl/riscv_dmem_array.sv
// riscv_dmem_array
//   DEPTH_WORDS x 32 single-port synchronous RAM with per-byte write strobe.
//   A read and a write in the same cycle return the old word. Contents are
//   never reset.
//
//   Ports: clk, we, strobe[3:0], index[AW-1:0], wdata[31:0], re,
//          rdata[31:0] (registered, updates only when re is high)
module riscv_dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    strobe,
    input  logic [AW-1:0] index,
    input  logic [31:0]   wdata,
    input  logic          re,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[index];
        end
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (strobe[i]) begin
                    mem[index][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/riscv_data_mem.sv
// riscv_data_mem
//   Word-organised data RAM behind a request/ready handshake. Byte, halfword
//   and word accesses; stores are steered onto byte lanes, loads come back
//   right-aligned and zero-filled after WAIT_STATES extra cycles.
//
//   Parameters: DEPTH_WORDS (power of two, >= 4), WAIT_STATES (0..15)
//   Ports:      clk, reset (synchronous, active high),
//               bus (riscv_data_mem_if.slave),
//               state_dbg (current FSM state, for observation only)
//   Macro:      RISCV_DMEM_ERR_EN enables alignment/size/range error checks;
//               without it misaligned offsets are ignored, the reserved size
//               acts as a word access and high address bits alias.
module riscv_data_mem
    import riscv_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    riscv_data_mem_if.slave bus,
    output dmem_state_t state_dbg
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_state_t state, state_next;
    logic [3:0]  wait_cnt;

    logic          accept;
    logic [AW-1:0] word_idx;
    logic [1:0]    lane_off;
    logic [1:0]    req_size;
    logic [1:0]    eff_size;
    logic          req_err;

    // Attributes of the access in flight, captured on acceptance.
    logic          acc_wr;
    logic          acc_err;
    logic [1:0]    acc_size;
    logic [1:0]    acc_off;

    logic [31:0]   rd_word;
    logic          ready;
    logic          err;
    logic [31:0]   rd_data;

    assign accept   = (state == IDLE) && bus.data_mem_req_i;
    assign word_idx = bus.data_mem_addr_i[AW+1:2];
    assign lane_off = bus.data_mem_addr_i[1:0];
    assign req_size = bus.data_mem_byte_en_i;

`ifdef RISCV_DMEM_ERR_EN
    assign eff_size = req_size;

    always_comb begin
        req_err = 1'b0;
        case (req_size)
            Reserved_Access: req_err = 1'b1;
            Halfword_Access: req_err = lane_off[0];
            Word_Access:     req_err = (lane_off != 2'b00);
            default:         req_err = 1'b0;
        endcase
        if ((bus.data_mem_addr_i >> (AW + 2)) != 32'd0) begin
            req_err = 1'b1;
        end
    end
`else
    logic unused_addr_hi;

    assign eff_size       = (req_size == Reserved_Access) ? Word_Access : req_size;
    assign req_err        = 1'b0;
    assign unused_addr_hi = ^bus.data_mem_addr_i[31:AW+2];
`endif

    // Stores commit and loads read on the acceptance edge. Accesses are
    // strictly serialised, so a load always follows the earlier store's
    // write edge and no forwarding path is required.
    riscv_dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk    (clk),
        .we     (accept && bus.data_mem_wr_i && !req_err),
        .strobe (dmem_strobe(eff_size, lane_off)),
        .index  (word_idx),
        .wdata  (dmem_wr_lanes(bus.data_mem_wr_data_i, eff_size)),
        .re     (accept && !bus.data_mem_wr_i && !req_err),
        .rdata  (rd_word)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                wait_cnt <= 4'(WAIT_STATES);
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    // Accepted-access attributes
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_wr   <= 1'b0;
            acc_err  <= 1'b0;
            acc_size <= 2'b00;
            acc_off  <= 2'b00;
        end else if (accept) begin
            acc_wr   <= bus.data_mem_wr_i;
            acc_err  <= req_err;
            acc_size <= eff_size;
            acc_off  <= lane_off;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.data_mem_req_i) begin
                    state_next = (WAIT_STATES > 0) ? WAIT : ACK;
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd1) begin
                    state_next = ACK;
                end
            end
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs. The array's output register holds the loaded word for the
    // whole access; lane selection follows it so the data is already
    // present in the first cycle after acceptance when WAIT_STATES is 0.
    always_comb begin
        ready   = (state == ACK);
        err     = 1'b0;
        rd_data = 32'd0;
        if (ready) begin
`ifdef RISCV_DMEM_ERR_EN
            err = acc_err;
`endif
            if (!acc_wr && !acc_err) begin
                rd_data = dmem_lane_sel(rd_word, acc_size, acc_off);
            end
        end
    end

    assign bus.mem_ready_o   = ready;
    assign bus.mem_err_o     = err;
    assign bus.mem_rd_data_o = rd_data;
    assign state_dbg         = state;

endmodule

// File: tb/tb_riscv_data_mem.sv
// tb_riscv_data_mem
//   Directed bench for riscv_data_mem. One instance with WAIT_STATES=2 runs a
//   table of accesses plus a reset-abort sequence; a second instance with
//   WAIT_STATES=0 runs a back-to-back held-request sequence.
//   Expected error/data values follow RISCV_DMEM_ERR_EN when it is defined.
module tb_riscv_data_mem;
    import riscv_pkg::*;

`ifdef RISCV_DMEM_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    riscv_data_mem_if bus2();
    riscv_data_mem_if bus0();
    dmem_state_t state2, state0;

    riscv_data_mem #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u_dut_ws2 (
        .clk(clk), .reset(reset), .bus(bus2), .state_dbg(state2)
    );

    riscv_data_mem #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut_ws0 (
        .clk(clk), .reset(reset), .bus(bus0), .state_dbg(state0)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
        vec_t v;
        v.wr = wr; v.size = size; v.addr = addr; v.wdata = wdata;
        v.exp_rd = exp_rd; v.exp_err = exp_err;
        return v;
    endfunction

    // ---------------- driver (WAIT_STATES=2 instance) ----------------
    task automatic ws2_access(input vec_t v, input string tag);
        logic [31:0] rd;
        logic        er;
        int          lat;
        bit          got;
        @(negedge clk);
        bus2.data_mem_req_i     = 1'b1;
        bus2.data_mem_wr_i      = v.wr;
        bus2.data_mem_byte_en_i = v.size;
        bus2.data_mem_addr_i    = v.addr;
        bus2.data_mem_wr_data_i = v.wdata;
        @(posedge clk);
        got = 1'b0; lat = 0; rd = '0; er = 1'b0;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge clk);
            if (bus2.mem_ready_o) begin
                got = 1'b1;
                lat = c;
                rd  = bus2.mem_rd_data_o;
                er  = bus2.mem_err_o;
                bus2.data_mem_req_i = 1'b0;
            end
        end
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL %s timeout: no ready within 20 cycles, expected ready after 3", tag);
            bus2.data_mem_req_i = 1'b0;
        end else begin
            check32({tag, " latency"}, 32'(lat), 32'd3);
            check32({tag, " rd_data"}, rd, v.exp_rd);
            check32({tag, " err"}, 32'(er), 32'(v.exp_err));
            @(negedge clk);
            check32({tag, " ready single pulse"}, 32'(bus2.mem_ready_o), 32'd0);
        end
    endtask

    // ---------------- WAIT_STATES=0 sequence data ----------------
    localparam int NOPS = 6;
    logic        ops_wr   [NOPS] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [1:0]  ops_size [NOPS] = '{2'b11, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11};
    logic [31:0] ops_addr [NOPS] = '{32'h10, 32'h14, 32'h10, 32'h15, 32'h16, 32'h14};
    logic [31:0] ops_wdat [NOPS] = '{32'h01020304, 32'hA0B0C0D0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] ops_exp  [NOPS] = '{32'h0, 32'h0, 32'h01020304, 32'h000000C0, 32'h0000A0B0, 32'hA0B0C0D0};

    task automatic ws0_apply(input int k);
        bus0.data_mem_req_i     = 1'b1;
        bus0.data_mem_wr_i      = ops_wr[k];
        bus0.data_mem_byte_en_i = ops_size[k];
        bus0.data_mem_addr_i    = ops_addr[k];
        bus0.data_mem_wr_data_i = ops_wdat[k];
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main test ----------------
    initial begin
        vecs[0]  = mk(1'b1, 2'b11, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0);
        vecs[1]  = mk(1'b0, 2'b00, 32'h13,   32'h0,        32'h000000DE, 1'b0);
        vecs[2]  = mk(1'b1, 2'b11, 32'h20,   32'h11223344, 32'h0,        1'b0);
        vecs[3]  = mk(1'b1, 2'b00, 32'h21,   32'h123456A5, 32'h0,        1'b0);
        vecs[4]  = mk(1'b0, 2'b11, 32'h20,   32'h0,        32'h1122A544, 1'b0);
        vecs[5]  = mk(1'b0, 2'b01, 32'h22,   32'h0,        32'h00001122, 1'b0);
        vecs[6]  = mk(1'b1, 2'b11, 32'h04,   32'h55667788, 32'h0,        1'b0);
        vecs[7]  = mk(1'b0, 2'b11, 32'h06,   32'h0,        ERR_EN ? 32'h0 : 32'h55667788, ERR_EN);
        vecs[8]  = mk(1'b0, 2'b11, 32'h04,   32'h0,        32'h55667788, 1'b0);
        vecs[9]  = mk(1'b1, 2'b01, 32'h12,   32'hFFFF1234, 32'h0,        1'b0);
        vecs[10] = mk(1'b0, 2'b11, 32'h10,   32'h0,        32'h1234BEEF, 1'b0);
        vecs[11] = mk(1'b0, 2'b01, 32'h10,   32'h0,        32'h0000BEEF, 1'b0);
        vecs[12] = mk(1'b0, 2'b00, 32'h11,   32'h0,        32'h000000BE, 1'b0);
        vecs[13] = mk(1'b0, 2'b11, 32'h1020, 32'h0,        ERR_EN ? 32'h0 : 32'h1122A544, ERR_EN);
        vecs[14] = mk(1'b0, 2'b10, 32'h20,   32'h0,        ERR_EN ? 32'h0 : 32'h1122A544, ERR_EN);
        vecs[15] = mk(1'b1, 2'b01, 32'h05,   32'h0000FFFF, 32'h0,        ERR_EN);
        vecs[16] = mk(1'b0, 2'b11, 32'h04,   32'h0,        ERR_EN ? 32'h55667788 : 32'h5566FFFF, 1'b0);

        reset = 1'b1;
        bus2.data_mem_req_i = 1'b0; bus2.data_mem_wr_i = 1'b0; bus2.data_mem_byte_en_i = 2'b00;
        bus2.data_mem_addr_i = '0;  bus2.data_mem_wr_data_i = '0;
        bus0.data_mem_req_i = 1'b0; bus0.data_mem_wr_i = 1'b0; bus0.data_mem_byte_en_i = 2'b00;
        bus0.data_mem_addr_i = '0;  bus0.data_mem_wr_data_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state and five idle cycles
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check32($sformatf("idle%0d ready", i), 32'(bus2.mem_ready_o), 32'd0);
            check32($sformatf("idle%0d err", i), 32'(bus2.mem_err_o), 32'd0);
            check32($sformatf("idle%0d rd_data", i), bus2.mem_rd_data_o, 32'd0);
            check32($sformatf("idle%0d state", i), 32'(state2), 32'(IDLE));
        end
        check32("ws0 reset ready", 32'(bus0.mem_ready_o), 32'd0);

        // Table-driven accesses
        for (int i = 0; i < NVEC; i++) begin
            ws2_access(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset during WAIT after an accepted store
        @(negedge clk);
        bus2.data_mem_req_i     = 1'b1;
        bus2.data_mem_wr_i      = 1'b1;
        bus2.data_mem_byte_en_i = 2'b11;
        bus2.data_mem_addr_i    = 32'h30;
        bus2.data_mem_wr_data_i = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        check32("abort in WAIT", 32'(state2), 32'(WAIT));
        reset = 1'b1;
        bus2.data_mem_req_i = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check32("abort state after reset", 32'(state2), 32'(IDLE));
        for (int i = 0; i < 4; i++) begin
            check32($sformatf("abort no ready %0d", i), 32'(bus2.mem_ready_o), 32'd0);
            @(negedge clk);
        end
        ws2_access(mk(1'b0, 2'b11, 32'h30, 32'h0, 32'hCAFEF00D, 1'b0), "abort reload");

        // Back-to-back accesses with the request held high, zero wait states
        begin
            int  k;
            int  last_c;
            for (int i = 0; i < NOPS; i++) exp_q.push_back(ops_exp[i]);
            k = 0;
            last_c = -1;
            @(negedge clk);
            ws0_apply(0);
            for (int c = 0; c < 60 && k < NOPS; c++) begin
                @(negedge clk);
                if (bus0.mem_ready_o) begin
                    check32($sformatf("ws0 op%0d rd_data", k), bus0.mem_rd_data_o, exp_q.pop_front());
                    check32($sformatf("ws0 op%0d err", k), 32'(bus0.mem_err_o), 32'd0);
                    if (k == 0) check32("ws0 first latency", 32'(c), 32'd0);
                    else        check32($sformatf("ws0 op%0d spacing", k), 32'(c - last_c), 32'd2);
                    last_c = c;
                    k++;
                    if (k < NOPS) ws0_apply(k);
                    else          bus0.data_mem_req_i = 1'b0;
                end
            end
            if (k < NOPS) begin
                n_checks++; n_fail++;
                $display("FAIL ws0 timeout: %0d of %0d accesses completed", k, NOPS);
                bus0.data_mem_req_i = 1'b0;
            end
            @(negedge clk);
            check32("ws0 idle after sequence", 32'(bus0.mem_ready_o), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
